// File: rtl/gold_tx_multi_if.sv
// AXI-Stream style descriptor channel carrying per-channel shift/data descriptors.
interface axistream_if #(
   parameter int DATA_W = 8
) ();
   logic [DATA_W-1:0] tdata;
   logic              tvalid;
   logic              tready;
   logic              tlast;

   modport master (output tdata, output tvalid, output tlast, input tready);
   modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/gold_tx_multi.sv
// Multi-channel Gold-code burst transmitter: loads one shift descriptor per channel, then plays the codes.
// Optional macro GOLD_TX_DATA_MOD_EN enables per-channel BPSK inversion from tdata[NUM_W].
//
// state | meaning
// IDLE  | waiting for strobe, outputs quiet
// LOAD  | accepting one descriptor per channel, in channel order
// OUT   | playing M_WIDTH chips, SYM_CYC cycles each, LSB first
// PAUSE | PAUSE_CYC silent cycles before returning to IDLE
module gold_tx_multi #(
   parameter int                 N_CH      = 4,
   parameter int                 M_WIDTH   = 31,
   parameter logic [M_WIDTH-1:0] M0_VAL    = 31'b1111100110100100001010111011000,
   parameter logic [M_WIDTH-1:0] M1_VAL    = 31'b1111101110001010110100001100100,
   parameter int                 SYM_CYC   = 10,
   parameter int                 PAUSE_CYC = 100
) (
   input  logic            s_axis_aclk,
   input  logic            aresetn,
   input  logic            strobe,
   axistream_if.slave      s_axis,
   output logic [N_CH-1:0] phase_out,
   output logic            busy,
   output logic            code_start,
   output logic            chip_stb,
   output logic            shift_err
);
   localparam int NUM_W = $clog2(M_WIDTH);
   localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int SYM_W = $clog2(SYM_CYC) + 1;
   localparam int PAU_W = $clog2(PAUSE_CYC) + 1;

   localparam logic [NUM_W:0]   M_LIM      = (NUM_W+1)'(M_WIDTH);
   localparam logic [NUM_W-1:0] LAST_CHIP  = NUM_W'(M_WIDTH - 1);
   localparam logic [CH_W-1:0]  LAST_CH    = CH_W'(N_CH - 1);
   localparam logic [SYM_W-1:0] SYM_LOAD   = SYM_W'(SYM_CYC - 1);
   localparam logic [PAU_W-1:0] PAUSE_LOAD = PAU_W'(PAUSE_CYC - 1);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_OUT, S_PAUSE} state_t;

   state_t             r_state;
   logic               r_tready;
   logic [N_CH-1:0]    r_phase;
   logic               r_busy;
   logic               r_code_start;
   logic               r_chip_stb;
   logic               r_shift_err;
   logic [CH_W-1:0]    r_ch_cnt;
   logic [NUM_W-1:0]   r_chip_idx;
   logic [SYM_W-1:0]   r_sym_cnt;
   logic [PAU_W-1:0]   r_pause_cnt;
   logic [M_WIDTH-1:0] r_code [N_CH];

   logic [NUM_W-1:0]   w_k;
   logic               w_bad;
   logic [NUM_W-1:0]   w_k_eff;
   logic [M_WIDTH-1:0] w_code_load;
   logic [NUM_W-1:0]   w_next_idx;
   logic               w_hs;
   logic               w_unused;

   // out[i] = v[(i+k) mod M]; the index sum never exceeds 2*(M-1), so one subtraction folds it.
   function automatic logic [M_WIDTH-1:0] rotr(input logic [M_WIDTH-1:0] v, input logic [NUM_W-1:0] k);
      logic [M_WIDTH-1:0] res;
      logic [NUM_W:0]     s;
      res = '0;
      for (int i = 0; i < M_WIDTH; i++) begin
         s = (NUM_W+1)'(i) + {1'b0, k};
         if (s >= M_LIM) s = s - M_LIM;
         res[i] = v[s[NUM_W-1:0]];
      end
      return res;
   endfunction

   assign w_k        = s_axis.tdata[NUM_W-1:0];
   assign w_bad      = ({1'b0, w_k} >= M_LIM);
   assign w_k_eff    = w_bad ? '0 : w_k;
   assign w_hs       = s_axis.tvalid & r_tready;
   assign w_next_idx = r_chip_idx + 1'b1;
   assign w_unused   = &{1'b0, s_axis.tlast, s_axis.tdata};

`ifdef GOLD_TX_DATA_MOD_EN
   assign w_code_load = M0_VAL ^ rotr(M1_VAL, w_k_eff) ^ {M_WIDTH{s_axis.tdata[NUM_W]}};
`else
   assign w_code_load = M0_VAL ^ rotr(M1_VAL, w_k_eff);
`endif

   always_ff @(posedge s_axis_aclk) begin
      if (!aresetn) begin
         r_state      <= S_IDLE;
         r_tready     <= 1'b0;
         r_phase      <= '0;
         r_busy       <= 1'b0;
         r_code_start <= 1'b0;
         r_chip_stb   <= 1'b0;
         r_shift_err  <= 1'b0;
         r_ch_cnt     <= '0;
         r_chip_idx   <= '0;
         r_sym_cnt    <= '0;
         r_pause_cnt  <= '0;
         for (int ch = 0; ch < N_CH; ch++) r_code[ch] <= '0;
      end else begin
         r_code_start <= 1'b0;
         r_chip_stb   <= 1'b0;
         r_shift_err  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_phase <= '0;
               if (strobe) begin
                  r_state  <= S_LOAD;
                  r_tready <= 1'b1;
                  r_busy   <= 1'b1;
                  r_ch_cnt <= '0;
               end
            end
            S_LOAD: begin
               if (w_hs) begin
                  r_code[r_ch_cnt] <= w_code_load;
                  r_shift_err      <= w_bad;
                  if (r_ch_cnt == LAST_CH) begin
                     r_state      <= S_OUT;
                     r_tready     <= 1'b0;
                     r_ch_cnt     <= '0;
                     r_chip_idx   <= '0;
                     r_sym_cnt    <= SYM_LOAD;
                     r_code_start <= 1'b1;
                     r_chip_stb   <= 1'b1;
                     // The last channel's code lands in r_code on this same edge, so take chip 0 from the load path.
                     for (int ch = 0; ch < N_CH; ch++)
                        r_phase[ch] <= (ch == N_CH - 1) ? w_code_load[0] : r_code[ch][0];
                  end else begin
                     r_ch_cnt <= r_ch_cnt + 1'b1;
                  end
               end
            end
            S_OUT: begin
               if (r_sym_cnt == '0) begin
                  if (r_chip_idx == LAST_CHIP) begin
                     r_state     <= S_PAUSE;
                     r_phase     <= '0;
                     r_pause_cnt <= PAUSE_LOAD;
                  end else begin
                     r_chip_idx <= w_next_idx;
                     r_sym_cnt  <= SYM_LOAD;
                     r_chip_stb <= 1'b1;
                     for (int ch = 0; ch < N_CH; ch++)
                        r_phase[ch] <= r_code[ch][w_next_idx];
                  end
               end else begin
                  r_sym_cnt <= r_sym_cnt - 1'b1;
               end
            end
            S_PAUSE: begin
               if (r_pause_cnt == '0) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_pause_cnt <= r_pause_cnt - 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign s_axis.tready = r_tready;
   assign phase_out     = r_phase;
   assign busy          = r_busy;
   assign code_start    = r_code_start;
   assign chip_stb      = r_chip_stb;
   assign shift_err     = r_shift_err;
endmodule

// File: doc/gold_tx_multi.md
GOLD_TX_MULTI -- requirements
Module: gold_tx_multi

Interface
REQ-001 Parameter N_CH, default 4, number of parallel Gold-code channels (1..16).
REQ-002 Parameter M_WIDTH, default 31, chips per code; NUM_W = $clog2(M_WIDTH) is derived internally.
REQ-003 Parameter M0_VAL, default 'b1111100110100100001010111011000, base m-sequence (M_WIDTH bits).
REQ-004 Parameter M1_VAL, default 'b1111101110001010110100001100100, shifted m-sequence (M_WIDTH bits).
REQ-005 Parameter SYM_CYC, default 10, clock cycles per chip (>=1).
REQ-006 Parameter PAUSE_CYC, default 100, clock cycles of silence after a code burst (>=1).
REQ-007 s_axis_aclk  input  1  clock for all logic.
REQ-008 aresetn  input  1  reset, synchronous, active-low.
REQ-009 strobe  input  1  starts one burst when sampled high in IDLE.
REQ-010 s_axis  axistream_if.slave  tdata>=NUM_W+1  per-channel descriptor; tdata[NUM_W-1:0] = shift k, tdata[NUM_W] = data bit; tlast ignored.
REQ-011 phase_out  output  N_CH  per-channel chip output.
REQ-012 busy  output  1  high whenever state is not IDLE.
REQ-013 code_start  output  1  one-cycle pulse on the first OUT cycle.
REQ-014 chip_stb  output  1  one-cycle pulse on the first cycle of every chip.
REQ-015 shift_err  output  1  one-cycle pulse the cycle after a handshake carrying k >= M_WIDTH.

Function
REQ-016 The FSM SHALL have exactly the states IDLE, LOAD, OUT and PAUSE.
REQ-017 IDLE: tready = 0 and phase_out = 0; strobe high moves to LOAD, with tready = 1 from the next cycle.
REQ-018 LOAD: the n-th handshake (tvalid & tready) SHALL load channel n-1, in order 0..N_CH-1; tvalid low stalls with no state change.
REQ-019 Per handshake, code_reg[ch] SHALL be loaded with M0_VAL XOR rotr(M1_VAL, k); rotr is a rotate-right within M_WIDTH bits.
REQ-020 k >= M_WIDTH SHALL be replaced by k = 0 and SHALL pulse shift_err.
REQ-021 After the N_CH-th handshake, tready SHALL be 0 on the next cycle and the state SHALL be OUT.
REQ-022 OUT: phase_out[ch] SHALL equal code_reg[ch][chip_idx], with chip_idx running 0 to M_WIDTH-1 (LSB first).
REQ-023 Each chip SHALL be held for exactly SYM_CYC cycles, so OUT lasts exactly M_WIDTH*SYM_CYC cycles.
REQ-024 After the last cycle of chip M_WIDTH-1, the state SHALL become PAUSE.
REQ-025 PAUSE: phase_out = 0 for exactly PAUSE_CYC cycles, then IDLE; the next burst may start on the first IDLE cycle.
REQ-026 strobe SHALL be ignored in LOAD, OUT and PAUSE, with no queuing.
REQ-027 All outputs SHALL be registered or decoded from registers only; there is no combinational path from s_axis or strobe to any output.

Reset
REQ-028 When aresetn is low, the block SHALL set: state IDLE, tready 0, phase_out 0, busy 0, code_start/chip_stb/shift_err 0, all counters 0, all code_reg 0.
REQ-029 Reset in any state, including mid-OUT or mid-LOAD, SHALL drive the REQ-028 values on the next clock edge; partially loaded descriptors are discarded.

Configuration
REQ-030 Macro GOLD_TX_DATA_MOD_EN, when defined: code_reg[ch] SHALL be inverted when the descriptor data bit tdata[NUM_W] = 1 (BPSK data modulation per channel).
REQ-031 Without GOLD_TX_DATA_MOD_EN: tdata[NUM_W] SHALL be ignored, and no inversion logic is synthesised.

Verification
REQ-032 Verification setup: N_CH=2, SYM_CYC=2, PAUSE_CYC=4, default sequences.
- k=0 on both channels -> both phase_out = (M0^M1) LSB-first, each chip 2 cycles.
- k=0 on both channels -> OUT lasts 62 cycles; code_start pulses once; chip_stb pulses 31 times.
- k=5 on ch0, k=30 on ch1 -> ch0 = M0^rotr(M1,5), ch1 = M0^rotr(M1,30); shift_err stays 0.
- k=31 on ch0 -> shift_err pulses once; ch0 output is identical to the k=0 case.
- tvalid dropped for 3 cycles between beats, strobe pulsed during OUT and PAUSE -> LOAD waits; exactly one burst occurs; busy falls after PAUSE.
- aresetn low at chip 10 of OUT -> next cycle phase_out = 0, busy = 0; a new strobe gives a full 31-chip burst from chip 0.
- GOLD_TX_DATA_MOD_EN defined, data bit 1 on ch1 -> ch1 is the bitwise inverse of the undefined-macro output; ch0 is unchanged.
